// File: rtl/consmax_stream_mh.sv
// consmax_stream_mh
//   Multi-head streaming ConSmax exponent/normalise engine. Each lane takes a
//   signed score, looks it up in a shared run-time-loadable exponent LUT,
//   right-shifts the result with saturation and emits it over a valid/ready
//   handshake. Rows are framed with odata_last. A per-row sum of the
//   unshifted LUT values is published for downstream renormalisation.
//
// Ports
//   clk, rst                   clock; asynchronous active-high reset
//   cfg_shift                  right shift applied to the LUT value
//   cfg_row_len                elements per row (0 selects ROW_LEN)
//   lut_wen/lut_waddr/lut_wdata LUT write port; a write stalls every lane
//   idata/idata_valid/idata_ready   per-lane score input handshake
//   odata/odata_valid/odata_ready   per-lane result output handshake
//   odata_last                 final element of a row
//   row_sum/row_sum_valid      per-lane row exponent sum, one-cycle pulse
module consmax_stream_mh #(
    parameter int NUM_HEAD  = 4,
    parameter int IDATA_BIT = 8,
    parameter int ODATA_BIT = 8,
    parameter int LUT_DATA  = 16,
    parameter int ROW_LEN   = 64,
    localparam int SUM_BIT  = LUT_DATA + $clog2(ROW_LEN),
    localparam int LEN_BIT  = $clog2(ROW_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    cfg_shift,
    input  logic [LEN_BIT-1:0]            cfg_row_len,
    input  logic                          lut_wen,
    input  logic [IDATA_BIT-1:0]          lut_waddr,
    input  logic [LUT_DATA-1:0]           lut_wdata,
    input  logic [NUM_HEAD*IDATA_BIT-1:0] idata,
    input  logic [NUM_HEAD-1:0]           idata_valid,
    output logic [NUM_HEAD-1:0]           idata_ready,
    output logic [NUM_HEAD*ODATA_BIT-1:0] odata,
    output logic [NUM_HEAD-1:0]           odata_valid,
    input  logic [NUM_HEAD-1:0]           odata_ready,
    output logic [NUM_HEAD-1:0]           odata_last,
    output logic [NUM_HEAD*SUM_BIT-1:0]   row_sum,
    output logic [NUM_HEAD-1:0]           row_sum_valid
);

    localparam int                  LUT_DEPTH = 1 << IDATA_BIT;
    localparam int                  CNT_BIT   = $clog2(ROW_LEN);
    localparam logic [LUT_DATA-1:0] OUT_MAX   = LUT_DATA'((1 << ODATA_BIT) - 1);
    localparam logic [LEN_BIT-1:0]  LEN_MAX   = LEN_BIT'(ROW_LEN);

    // Shared exponent table, indexed by the raw two's-complement score bits.
    logic [LUT_DATA-1:0] lut_q [LUT_DEPTH];

    // NOTE: the table is a flop array, not a RAM macro, because every entry
    // must read back as zero right after reset; a RAM could not be cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
        end else if (lut_wen) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    for (genvar h = 0; h < NUM_HEAD; h++) begin : g_lane
        logic [IDATA_BIT-1:0] score;
        logic                 s2_adv, s1_adv, accept, xfer, is_last;
        logic [LEN_BIT-1:0]   eff_len;
        logic [LUT_DATA-1:0]  shifted;
        logic [SUM_BIT:0]     sum_wide;
        logic [SUM_BIT-1:0]   sum_sat;

        logic                 s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
        logic [LUT_DATA-1:0]  s1_exp_q, s1_exp_d;
        logic [CNT_BIT-1:0]   cnt_q, cnt_d;
        logic [SUM_BIT-1:0]   acc_q, acc_d, row_sum_q, row_sum_d;
        logic [ODATA_BIT-1:0] odata_q, odata_d;
        logic                 ovalid_q, ovalid_d, olast_q, olast_d, rsv_q, rsv_d;

        assign score  = idata[h*IDATA_BIT +: IDATA_BIT];

        // Each stage moves when the stage after it is empty or draining, so
        // ready is combinational from odata_ready; a LUT write stalls input.
        assign s2_adv = !ovalid_q || odata_ready[h];
        assign s1_adv = !s1_valid_q || s2_adv;
        assign idata_ready[h] = s1_adv && !lut_wen;
        assign accept = idata_valid[h] && idata_ready[h];
        assign xfer   = s1_valid_q && s2_adv;

        assign eff_len = (cfg_row_len == '0) ? LEN_MAX : cfg_row_len;
        assign is_last = LEN_BIT'(cnt_q) >= (eff_len - LEN_BIT'(1));

        // A shift of LUT_DATA or more naturally drops every bit to zero.
        assign shifted  = s1_exp_q >> cfg_shift;
        assign sum_wide = {1'b0, acc_q} + (SUM_BIT + 1)'(s1_exp_q);
        assign sum_sat  = sum_wide[SUM_BIT] ? '1 : sum_wide[SUM_BIT-1:0];

        // NOTE: every next-state signal takes its hold value first, so no
        // path through this block can leave one unassigned and infer a latch.
        always_comb begin
            s1_valid_d = s1_valid_q;
            s1_last_d  = s1_last_q;
            s1_exp_d   = s1_exp_q;
            cnt_d      = cnt_q;
            acc_d      = acc_q;
            row_sum_d  = row_sum_q;
            odata_d    = odata_q;
            ovalid_d   = ovalid_q;
            olast_d    = olast_q;
            rsv_d      = 1'b0;

            if (accept) begin
                s1_valid_d = 1'b1;
                s1_exp_d   = lut_q[score];
                s1_last_d  = is_last;
                cnt_d      = is_last ? '0 : cnt_q + CNT_BIT'(1);
            end else if (s2_adv) begin
                s1_valid_d = 1'b0;
            end

            if (s2_adv) ovalid_d = s1_valid_q;

            if (xfer) begin
                odata_d = (shifted > OUT_MAX) ? '1 : shifted[ODATA_BIT-1:0];
                olast_d = s1_last_q;
                if (s1_last_q) begin
                    // The last element's exp is folded into the published sum.
                    row_sum_d = sum_sat;
                    rsv_d     = 1'b1;
                    acc_d     = '0;
                end else begin
                    acc_d = sum_sat;
                end
            end
        end

        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge value regardless of statement order.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_valid_q <= 1'b0;
                s1_last_q  <= 1'b0;
                s1_exp_q   <= '0;
                cnt_q      <= '0;
                acc_q      <= '0;
                row_sum_q  <= '0;
                odata_q    <= '0;
                ovalid_q   <= 1'b0;
                olast_q    <= 1'b0;
                rsv_q      <= 1'b0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_last_q  <= s1_last_d;
                s1_exp_q   <= s1_exp_d;
                cnt_q      <= cnt_d;
                acc_q      <= acc_d;
                row_sum_q  <= row_sum_d;
                odata_q    <= odata_d;
                ovalid_q   <= ovalid_d;
                olast_q    <= olast_d;
                rsv_q      <= rsv_d;
            end
        end

        assign odata[h*ODATA_BIT +: ODATA_BIT] = odata_q;
        assign odata_valid[h]                  = ovalid_q;
        assign odata_last[h]                   = olast_q;
        assign row_sum[h*SUM_BIT +: SUM_BIT]   = row_sum_q;
        assign row_sum_valid[h]                = rsv_q;
    end

endmodule
